// File: rtl/riscy_pkg.sv
// Shared types for the fetch stage: FSM states, FIFO entry layout, PC increment.
package riscy_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Flushable synchronous FIFO of {pc, instr} entries. Flush wins over push.
// head_o reads as all-zero while the FIFO is empty.
module fetch_fifo
  import riscy_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  fetch_entry_t       entry_i,
  input  logic               pop_i,
  input  logic               flush_i,
  output logic [CntW-1:0]    count_o,
  output logic               empty_o,
  output fetch_entry_t       head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [PtrW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  fetch_entry_t    mem_q [Depth];
  logic            full, do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == CntW'(Depth));
  assign do_pop  = pop_i & ~empty_o;
  // A push into a full FIFO is only taken when the head leaves the same cycle.
  assign do_push = push_i & (~full | do_pop);
  assign count_o = cnt_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_q];

  // Pointer and occupancy next-state.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_pop)  rd_d = ptr_inc(rd_q);
      if (do_push) wr_d = ptr_inc(wr_q);
      cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= entry_i;
  end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: PC ownership, single-outstanding imem reads,
// buffered delivery to decode, redirect flush.
// Optional macro FETCH_PERF_EN adds pop and stall performance counters.
module fetch
  import riscy_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        instr_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        halt_i
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_stall_o
`endif
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  fetch_state_e    state_q, state_d;
  logic [31:0]     pc_q, pc_d, tag_q, tag_d;
  logic            inflight_q, inflight_d, squash_q, squash_d;
  logic            run, pop, accept, resp, push;
  logic [31:0]     occ;
  logic [CntW-1:0] fifo_count;
  logic            fifo_empty;
  fetch_entry_t    fifo_head, push_entry;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  // FSM next state: every state leaves for HALTED or RUN based on halt_i.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = halt_i ? HALTED : RUN;
      RUN:     state_d = halt_i ? HALTED : RUN;
      HALTED:  state_d = halt_i ? HALTED : RUN;
      default: state_d = BOOT;
    endcase
  end

  // FSM output decode.
  always_comb begin
    run = (state_q == RUN);
  end

  // Handshakes: room counts buffered entries plus the outstanding read.
  always_comb begin
    instr_valid_o = ~fifo_empty & ~redirect_i;
    pop           = instr_valid_o & instr_ready_i;
    occ           = 32'(fifo_count) + {31'b0, inflight_q} - {31'b0, pop};
    imem_req_o    = run & ~redirect_i & (occ < DEPTH);
    imem_addr_o   = pc_q;
    accept        = imem_req_o & imem_ready_i;
    resp          = imem_rvalid_i & inflight_q;
    push          = resp & ~squash_q & ~redirect_i;
    push_entry    = '{pc: tag_q, instr: imem_rdata_i};
    instr_o       = fifo_head.instr;
    pc_o          = fifo_head.pc;
  end

  // PC, tag and outstanding-read tracking.
  always_comb begin
    pc_d       = pc_q;
    tag_d      = accept ? pc_q : tag_q;
    inflight_d = accept | (inflight_q & ~imem_rvalid_i);
    squash_d   = squash_q;
    if (redirect_i) begin
      pc_d     = redirect_pc_i & ~32'h3;
      // Only a read still outstanding after this cycle needs discarding later.
      squash_d = inflight_q & ~imem_rvalid_i;
    end else begin
      if (accept) pc_d = pc_q + PC_STEP;
      if (resp)   squash_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      squash_q   <= squash_d;
    end
  end

  fetch_fifo #(
    .Depth (DEPTH),
    .CntW  (CntW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  // Counters; valid is already low in a redirect cycle so neither counts there.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (pop)                            perf_fetched_q <= perf_fetched_q + 32'd1;
      if (instr_valid_o && !instr_ready_i) perf_stall_q  <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_stall_o   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch.sv
// Randomized bench for fetch with a transaction-level reference model.
// Define FETCH_PERF_EN to also check the performance counters.
module tb_fetch;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        halt_i;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_o, perf_stall_o;
`endif

  fetch #(
    .RESET_PC (32'h0),
    .DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ready_i  (imem_ready_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .instr_ready_i (instr_ready_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_i        (halt_i)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched_o (perf_fetched_o),
    .perf_stall_o   (perf_stall_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  // Memory: answers every accepted request exactly one cycle later,
  // and optionally emits stray rvalid pulses that must be ignored.
  bit          mem_acc;
  logic [31:0] mem_addr;
  bit          spurious_en = 0;
  always @(negedge clk) begin
    mem_acc  = imem_req_o & imem_ready_i;
    mem_addr = imem_addr_o;
  end
  always @(posedge clk) begin
    #1;
    imem_rvalid_i = mem_acc | (spurious_en && $urandom_range(0, 7) == 0);
    imem_rdata_i  = mem_acc ? memf(mem_addr) : $urandom;
  end

  // Reference model: a queue of delivered-but-unconsumed pairs, at most one
  // outstanding read tagged with a redirect epoch, and a run/halt flag.
  bit          m_known = 0;
  bit          m_running;
  logic [31:0] m_pc;
  logic [63:0] m_q[$];
  bit          m_pend;
  logic [31:0] m_pend_pc;
  int          m_pend_ep, m_ep;
  logic [31:0] m_fetched, m_stall;
  int          rel_cyc = 0;
  logic [31:0] log_pc[$];
  int          log_cyc[$];

  always @(negedge clk) begin
    bit          valid, pop, req, acc;
    logic [63:0] head;
    if (rst_n) rel_cyc++;
    if (m_known) begin
      valid = (m_q.size() != 0) && !redirect_i;
      pop   = valid && instr_ready_i;
      req   = m_running && !redirect_i &&
              (int'(m_q.size()) + int'(m_pend) - int'(pop) < int'(DEPTH));
      head  = (m_q.size() != 0) ? m_q[0] : 64'h0;
      chk("imem_req", {63'b0, imem_req_o}, {63'b0, req});
      if (req) chk("imem_addr", {32'b0, imem_addr_o}, {32'b0, m_pc});
      chk("instr_valid", {63'b0, instr_valid_o}, {63'b0, valid});
      chk("instr", {32'b0, instr_o}, {32'b0, head[31:0]});
      chk("pc", {32'b0, pc_o}, {32'b0, head[63:32]});
`ifdef FETCH_PERF_EN
      chk("perf_fetched", {32'b0, perf_fetched_o}, {32'b0, m_fetched});
      chk("perf_stall", {32'b0, perf_stall_o}, {32'b0, m_stall});
`endif
      if (rst_n && pop) begin
        log_pc.push_back(head[63:32]);
        log_cyc.push_back(rel_cyc);
      end
    end else begin
      req = 0; pop = 0; valid = 0;
    end
    if (!rst_n) begin
      m_known   = 1;
      m_running = 0;
      m_pc      = 32'h0;
      m_q.delete();
      m_pend    = 0;
      m_ep      = 0;
      m_fetched = 0;
      m_stall   = 0;
      rel_cyc   = 0;
      log_pc.delete();
      log_cyc.delete();
    end else if (m_known) begin
      acc = req && imem_ready_i;
      if (valid && !instr_ready_i) m_stall++;
      if (pop) m_fetched++;
      if (redirect_i) begin
        m_q.delete();
        m_ep++;
        m_pc = redirect_pc_i & ~32'h3;
      end else begin
        if (pop) void'(m_q.pop_front());
        if (imem_rvalid_i && m_pend && m_pend_ep == m_ep)
          m_q.push_back({m_pend_pc, memf(m_pend_pc)});
      end
      if (acc) begin
        m_pend    = 1;
        m_pend_pc = m_pc;
        m_pend_ep = m_ep;
        m_pc      = m_pc + 32'd4;
      end else if (imem_rvalid_i) begin
        m_pend = 0;
      end
      m_running = !halt_i;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    log_pc.delete();
    log_cyc.delete();
  endtask

  task automatic chk_seq(input string name);
    for (int i = 1; i < log_pc.size(); i++)
      chk(name, {32'b0, log_pc[i]}, {32'b0, log_pc[i-1] + 32'd4});
  endtask

  initial begin
    int r;
    rst_n = 0; imem_ready_i = 1; instr_ready_i = 1;
    redirect_i = 0; redirect_pc_i = 0; halt_i = 0;
    imem_rvalid_i = 0; imem_rdata_i = 0;
    step(3);

    // Reset release, everything ready: first delivery in cycle 4.
    rst_n = 1;
    step(12);
    chk("boot_pops", {63'b0, log_pc.size() >= 3}, 64'd1);
    if (log_pc.size() >= 3) begin
      chk("boot_first_cycle", 64'(log_cyc[0]), 64'd4);
      chk("boot_pc0", {32'b0, log_pc[0]}, 64'h0);
      chk("boot_pc1", {32'b0, log_pc[1]}, 64'h4);
      chk("boot_pc2", {32'b0, log_pc[2]}, 64'h8);
      chk("boot_rate", 64'(log_cyc[2] - log_cyc[0]), 64'd2);
    end
    chk_seq("boot_seq");

    // Decode stall: FIFO fills and requests stop; order kept on release.
    clear_log();
    instr_ready_i = 0;
    step(4);
    @(negedge clk);
    chk("stall_req_low", {63'b0, imem_req_o}, 64'd0);
    chk("stall_valid", {63'b0, instr_valid_o}, 64'd1);
    step(1);
    instr_ready_i = 1;
    step(8);
    chk_seq("stall_seq");

    // Memory back-pressure on 0x10: address held.
    redirect_i = 1; redirect_pc_i = 32'h10;
    step(1);
    redirect_i = 0; imem_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_req", {63'b0, imem_req_o}, 64'd1);
      chk("hold_addr", {32'b0, imem_addr_o}, 64'h10);
      step(1);
    end
    clear_log();
    imem_ready_i = 1;
    step(8);
    chk("hold_first", {32'b0, (log_pc.size() != 0) ? log_pc[0] : 32'hDEAD_BEEF}, 64'h10);
    chk_seq("hold_seq");

    // Redirect to 0x103 with a read in flight: next pc 0x100 three cycles on.
    clear_log();
    r = rel_cyc + 1;
    redirect_i = 1; redirect_pc_i = 32'h103;
    step(1);
    redirect_i = 0;
    step(6);
    chk("redir_pops", {63'b0, log_pc.size() != 0}, 64'd1);
    if (log_pc.size() != 0) begin
      chk("redir_pc", {32'b0, log_pc[0]}, 64'h100);
      chk("redir_cycle", 64'(log_cyc[0] - r), 64'd3);
    end

    // Halt: requests stop, buffer drains, resume at next sequential PC.
    clear_log();
    halt_i = 1;
    step(3);
    @(negedge clk);
    chk("halt_req", {63'b0, imem_req_o}, 64'd0);
    chk("halt_drained", {63'b0, instr_valid_o}, 64'd0);
    step(3);
    halt_i = 0;
    step(8);
    chk_seq("halt_seq");

    // PC wrap at the top of the address space.
    clear_log();
    redirect_i = 1; redirect_pc_i = 32'hFFFF_FFF9;
    step(1);
    redirect_i = 0;
    step(8);
    chk("wrap_pops", {63'b0, log_pc.size() >= 3}, 64'd1);
    if (log_pc.size() >= 3) begin
      chk("wrap_pc0", {32'b0, log_pc[0]}, 64'hFFFF_FFF8);
      chk("wrap_pc1", {32'b0, log_pc[1]}, 64'hFFFF_FFFC);
      chk("wrap_pc2", {32'b0, log_pc[2]}, 64'h0);
    end

    // Mid-run reset with a read outstanding: stale response ignored.
    rst_n = 0;
    step(1);
    rst_n = 1;
    step(10);

    // Randomized traffic.
    spurious_en = 1;
    for (int i = 0; i < 4000; i++) begin
      imem_ready_i  = ($urandom_range(0, 99) < 75);
      instr_ready_i = ($urandom_range(0, 99) < 70);
      redirect_i    = ($urandom_range(0, 99) < 3);
      redirect_pc_i = $urandom;
      if ($urandom_range(0, 99) < 4) halt_i = ~halt_i;
      rst_n         = ($urandom_range(0, 999) >= 3);
      step(1);
    end
    rst_n = 1; redirect_i = 0; halt_i = 0;
    step(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
